// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler
// Owns the single port of the 200x150 3-bit framebuffer. Video scan-out reads
// own the port during active video. Host pixel writes wait in a small FIFO and
// drain only during blanking. A full-screen clear to a programmable colour is
// also sequenced here, one word per blanking cycle.
//
// Ports:
//   CLK, RESET_N          pixel clock, asynchronous active-low reset
//   h_count, v_count      position from the VGA timing generator
//   wr_valid/wr_ready     host pixel push handshake, wr_data = {b,g,r}
//   addr_load, addr_in    load the host write pointer
//   clr_start, clr_color  start a full-screen clear with the given colour
//   clr_busy, clr_done    clear in progress / one-cycle completion pulse
//   mem_addr/we/wdata     framebuffer port (synchronous RAM, 1-cycle read)
//   mem_rdata             framebuffer read data
//   pix_rgb               registered pixel to the DAC, 0 during blanking
module fb_access_scheduler #(
   parameter int H_ACTIVE   = 200,
   parameter int V_ACTIVE   = 600,
   parameter int V_SHIFT    = 2,
   parameter int FB_SIZE    = 30000,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [8:0]        h_count,
   input  logic [9:0]        v_count,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_data,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              clr_start,
   input  logic [2:0]        clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [2:0]        mem_wdata,
   input  logic [2:0]        mem_rdata,
   output logic [2:0]        pix_rgb
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [8:0]        H_ACT_H  = 9'(H_ACTIVE);
   localparam logic [9:0]        V_ACT_V  = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_ACT_A  = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);
   localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_SIZE - 1);

   typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              clr_done_q, clr_done_d;
   logic [ADDR_W-1:0] host_ptr_q, host_ptr_d;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
   logic [2:0]        fifo_data_q [FIFO_DEPTH];
   logic [2:0]        fifo_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rdy_en_q, rdy_en_d;
   logic              act_d1_q, act_d1_d;
   logic [2:0]        pix_q, pix_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;

   logic              active, empty, full, push, pop, clr_wr;
   logic [ADDR_W-1:0] scan_addr, load_addr, base_ptr;
   logic [ADDR_W-1:0] addr_mux;
   logic              we_mux;
   logic [2:0]        wdata_mux;

   assign active    = (h_count < H_ACT_H) && (v_count < V_ACT_V);
   assign scan_addr = ADDR_W'(h_count) + ADDR_W'(v_count >> V_SHIFT) * H_ACT_A;
   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);

   // rdy_en_q keeps wr_ready low through reset and rises one cycle after release.
   assign wr_ready = rdy_en_q && !full && (state_q == ST_IDLE);
   assign push     = wr_valid && wr_ready;
   assign clr_busy = (state_q == ST_CLEAR);
   assign clr_done = clr_done_q;
   assign pix_rgb  = pix_q;

   // Scheduler FSM: IDLE drains the host queue in blanking, CLEAR walks the
   // whole framebuffer writing clr_color in blanking and pauses in active video.
   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      clr_done_d = 1'b0;
      pop        = 1'b0;
      clr_wr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pop = !active && !empty;
            // A clear request is only honoured with an empty queue, never deferred.
            if (clr_start && empty) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (!active) begin
               clr_wr = 1'b1;
               if (clr_ptr_q == FB_LAST) begin
                  state_d    = ST_IDLE;
                  clr_ptr_d  = '0;
                  clr_done_d = 1'b1;
               end else begin
                  clr_ptr_d = clr_ptr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Host pointer and queue. A same-cycle addr_load feeds the push directly,
   // so the pushed entry uses the loaded address and the pointer moves past it.
   always_comb begin
      load_addr  = (addr_in >= FB_SIZE_A) ? '0 : addr_in;
      base_ptr   = addr_load ? load_addr : host_ptr_q;
      host_ptr_d = base_ptr;
      if (push) begin
         host_ptr_d = (base_ptr == FB_LAST) ? '0 : base_ptr + ADDR_W'(1);
      end
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = base_ptr;
         fifo_data_d[wr_ptr_q] = wr_data;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Port mux: scan-out wins in active video; otherwise a queued write or a
   // clear write; otherwise the address is held with write enable low.
   always_comb begin
      addr_mux  = last_addr_q;
      we_mux    = 1'b0;
      wdata_mux = 3'b000;
      if (active) begin
         addr_mux = scan_addr;
      end else if (pop) begin
         addr_mux  = fifo_addr_q[rd_ptr_q];
         we_mux    = 1'b1;
         wdata_mux = fifo_data_q[rd_ptr_q];
      end else if (clr_wr) begin
         addr_mux  = clr_ptr_q;
         we_mux    = 1'b1;
         wdata_mux = clr_color;
      end
      last_addr_d = addr_mux;
      rdy_en_d    = 1'b1;
      // The active flag is delayed one cycle to line up with mem_rdata, and the
      // output register supplies the second stage.
      act_d1_d    = active;
      pix_d       = act_d1_q ? mem_rdata : 3'b000;
   end

   // The RAM port is forced to zero the moment reset asserts, not at the next edge.
   assign mem_addr  = RESET_N ? addr_mux  : '0;
   assign mem_we    = RESET_N ? we_mux    : 1'b0;
   assign mem_wdata = RESET_N ? wdata_mux : 3'b000;

   // State registers; reset aborts any clear or drain and empties the queue.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         clr_ptr_q   <= '0;
         clr_done_q  <= 1'b0;
         host_ptr_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdy_en_q    <= 1'b0;
         act_d1_q    <= 1'b0;
         pix_q       <= 3'b000;
         last_addr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= 3'b000;
         end
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         clr_done_q  <= clr_done_d;
         host_ptr_q  <= host_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rdy_en_q    <= rdy_en_d;
         act_d1_q    <= act_d1_d;
         pix_q       <= pix_d;
         last_addr_q <= last_addr_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
      end
   end

endmodule

// File: tb/tb_fb_access_scheduler.sv
// tb_fb_access_scheduler
// Directed bench for fb_access_scheduler. A behavioural synchronous RAM sits on
// the framebuffer port. Expected memory writes and expected pixels are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_fb_access_scheduler;

   localparam int FB = 30000;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [8:0]  h_count;
   logic [9:0]  v_count;
   logic        wr_valid, wr_ready, addr_load, clr_start, clr_busy, clr_done, mem_we;
   logic [2:0]  wr_data, clr_color, mem_wdata, mem_rdata, pix_rgb;
   logic [14:0] addr_in, mem_addr;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  data;
   } wr_t;

   logic [2:0] ram    [FB];
   logic [2:0] golden [FB];
   wr_t        exp_w [$];
   logic [2:0] pix_q [$];
   int         checks = 0;
   int         errors = 0;
   int         hp = 0;
   int         done_seen = 0;

   fb_access_scheduler dut (
      .CLK(CLK), .RESET_N(RESET_N), .h_count(h_count), .v_count(v_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .addr_load(addr_load), .addr_in(addr_in), .clr_start(clr_start),
      .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pix_rgb(pix_rgb)
   );

   // 10 MHz pixel clock
   always #50 CLK = ~CLK;

   // Synchronous single-port framebuffer with read-before-write
   always @(posedge CLK) begin
      if (int'(mem_addr) < FB) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end else begin
         mem_rdata <= 3'b000;
      end
   end

   // One comparison: counts it and reports a failure with tag/observed/expected
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle scoreboard work at the falling edge
   task automatic monitorCycle(input logic act);
      logic [2:0] e;
      wr_t        w;
      if (pix_q.size() == 3) begin
         e = pix_q.pop_front();
         checkOutput("pix_rgb", 32'(pix_rgb), 32'(e));
      end
      if (mem_we === 1'b1) begin
         checkOutput("we_in_active", 32'(act), 32'(0));
         checkOutput("pending_write_at_we", 32'(exp_w.size() > 0), 32'(1));
         if (exp_w.size() > 0) begin
            w = exp_w.pop_front();
            checkOutput("mem_addr", 32'(mem_addr), 32'(w.addr));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(w.data));
            golden[w.addr] = w.data;
         end
      end
      if (clr_done === 1'b1) done_seen++;
      // Host pointer model
      if (addr_load) hp = (int'(addr_in) >= FB) ? 0 : int'(addr_in);
      if (wr_valid && wr_ready) begin
         exp_w.push_back({15'(hp), wr_data});
         hp = (hp == FB - 1) ? 0 : hp + 1;
      end
   endtask

   // Drive one pixel-clock cycle at position (h,v); returns just after the next rising edge
   task automatic applyStimulus(input int h, input int v);
      logic act;
      h_count = 9'(h);
      v_count = 10'(v);
      act = (h < 200) && (v < 600);
      if (RESET_N) pix_q.push_back(act ? golden[h + (v >> 2) * 200] : 3'b000);
      @(negedge CLK);
      monitorCycle(act);
      @(posedge CLK);
      #1;
   endtask

   task automatic runSpan(input int h0, input int h1, input int v);
      for (int h = h0; h <= h1; h++) applyStimulus(h, v);
   endtask

   // Assert reset asynchronously, verify the outputs collapse, release after two edges
   task automatic doReset();
      RESET_N = 1'b0;
      h_count = 9'd5;
      v_count = 10'd10;
      #1;
      checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      checkOutput("rst_clr_busy", 32'(clr_busy), 32'(0));
      checkOutput("rst_clr_done", 32'(clr_done), 32'(0));
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'(0));
      checkOutput("rst_pix_rgb", 32'(pix_rgb), 32'(0));
      pix_q.delete();
      exp_w.delete();
      hp = 0;
      repeat (2) begin
         @(posedge CLK);
         if (clr_done === 1'b1) done_seen++;
      end
      #1;
      RESET_N = 1'b1;
      #1;
      checkOutput("wr_ready_cycle0", 32'(wr_ready), 32'(0));
   endtask

   initial begin
      int i;
      for (int k = 0; k < FB; k++) begin
         ram[k]    = 3'(k);
         golden[k] = 3'(k);
      end
      RESET_N   = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = 3'b000;
      addr_load = 1'b0;
      addr_in   = '0;
      clr_start = 1'b0;
      clr_color = 3'b000;
      h_count   = '0;
      v_count   = '0;
      @(posedge CLK);
      #1;
      doReset();

      // Line 0 scan-out plus queued host writes to 399..401
      applyStimulus(0, 0);
      checkOutput("wr_ready_cycle1", 32'(wr_ready), 32'(1));
      runSpan(1, 47, 0);
      addr_load = 1'b1;
      addr_in   = 15'd399;
      applyStimulus(48, 0);
      addr_load = 1'b0;
      applyStimulus(49, 0);
      for (int j = 0; j < 3; j++) begin
         wr_valid = 1'b1;
         wr_data  = 3'(1 << j);
         checkOutput("wr_ready_push", 32'(wr_ready), 32'(1));
         applyStimulus(50 + j, 0);
      end
      wr_valid = 1'b0;
      runSpan(53, 199, 0);
      checkOutput("held_until_blank", 32'(exp_w.size()), 32'(3));
      runSpan(200, 202, 0);
      checkOutput("drained_3", 32'(exp_w.size()), 32'(0));
      runSpan(203, 263, 0);
      runSpan(0, 263, 4);

      // Five pushes with wr_valid held through active video
      runSpan(0, 9, 5);
      wr_valid = 1'b1;
      for (int h = 10; h <= 201; h++) begin
         wr_data = 3'(h);
         if (h == 13) checkOutput("ready_before_full", 32'(wr_ready), 32'(1));
         if (h == 14) checkOutput("ready_when_full", 32'(wr_ready), 32'(0));
         if (h == 199) checkOutput("ready_full_active", 32'(wr_ready), 32'(0));
         if (h == 200) checkOutput("ready_full_at_pop", 32'(wr_ready), 32'(0));
         if (h == 201) checkOutput("ready_after_pop", 32'(wr_ready), 32'(1));
         applyStimulus(h, 5);
      end
      wr_valid = 1'b0;
      checkOutput("fifth_accepted", 32'(hp), 32'(407));
      runSpan(202, 263, 5);
      checkOutput("drained_5", 32'(exp_w.size()), 32'(0));
      runSpan(0, 263, 8);

      // Pointer wrap, out-of-range load, same-cycle load and push
      addr_load = 1'b1;
      addr_in   = 15'd29999;
      applyStimulus(0, 600);
      addr_load = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 3'd6;
      applyStimulus(1, 600);
      wr_data   = 3'd7;
      applyStimulus(2, 600);
      addr_load = 1'b1;
      addr_in   = 15'd30000;
      wr_data   = 3'd3;
      applyStimulus(3, 600);
      addr_load = 1'b0;
      wr_data   = 3'd5;
      applyStimulus(4, 600);
      wr_valid  = 1'b0;
      runSpan(5, 10, 600);
      checkOutput("drained_wrap", 32'(exp_w.size()), 32'(0));
      checkOutput("golden_29999", 32'(ram[29999]), 32'(6));
      checkOutput("ram_addr0", 32'(ram[0]), 32'(3));
      checkOutput("ram_addr1", 32'(ram[1]), 32'(5));

      // Full clear to 5 with a pause in active video and an ignored second start
      done_seen = 0;
      clr_color = 3'b101;
      clr_start = 1'b1;
      applyStimulus(20, 600);
      clr_start = 1'b0;
      for (int k = 0; k < FB; k++) exp_w.push_back({15'(k), 3'b101});
      checkOutput("clr_busy_rise", 32'(clr_busy), 32'(1));
      i = 0;
      while (clr_busy && i < 30200) begin
         if (i == 5000) clr_start = 1'b1;
         if (i == 6000) begin
            wr_valid = 1'b1;
            checkOutput("ready_in_clear", 32'(wr_ready), 32'(0));
         end
         if (i >= 100 && i < 150) applyStimulus(i - 100, 0);
         else applyStimulus(250, 600);
         clr_start = 1'b0;
         wr_valid  = 1'b0;
         i++;
      end
      checkOutput("clear_finished", 32'(clr_busy), 32'(0));
      runSpan(250, 253, 600);
      checkOutput("clr_done_pulses", 32'(done_seen), 32'(1));
      checkOutput("clear_writes_all", 32'(exp_w.size()), 32'(0));
      exp_w.delete();
      runSpan(0, 263, 0);
      runSpan(0, 263, 300);
      runSpan(150, 263, 599);

      // Reset mid-clear at clr_ptr 1000
      done_seen = 0;
      clr_color = 3'b010;
      clr_start = 1'b1;
      applyStimulus(250, 600);
      clr_start = 1'b0;
      for (int k = 0; k < 1000; k++) exp_w.push_back({15'(k), 3'b010});
      repeat (1000) applyStimulus(250, 600);
      checkOutput("busy_before_abort", 32'(clr_busy), 32'(1));
      checkOutput("writes_before_abort", 32'(exp_w.size()), 32'(0));
      doReset();
      runSpan(250, 260, 600);
      checkOutput("busy_after_abort", 32'(clr_busy), 32'(0));
      checkOutput("no_done_after_abort", 32'(done_seen), 32'(0));

      // Queued writes are discarded by reset
      runSpan(0, 9, 0);
      wr_valid = 1'b1;
      wr_data  = 3'd7;
      runSpan(10, 11, 0);
      wr_valid = 1'b0;
      checkOutput("queued_before_reset", 32'(exp_w.size()), 32'(2));
      doReset();
      runSpan(250, 259, 600);
      wr_valid = 1'b1;
      wr_data  = 3'd6;
      applyStimulus(260, 600);
      wr_valid = 1'b0;
      runSpan(261, 263, 600);
      checkOutput("post_reset_write", 32'(exp_w.size()), 32'(0));
      checkOutput("post_reset_ram0", 32'(ram[0]), 32'(6));
      runSpan(0, 263, 0);
      checkOutput("final_queue_empty", 32'(exp_w.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
- Owns the single port of the 200x150 3-bit framebuffer and time-shares it between video scan-out reads and host pixel writes.
- Scan-out always has priority during active video. Host writes are queued in a small FIFO and drained only during horizontal or vertical blanking.
- Also sequences a full-screen clear to a programmable colour.
- Sits between the VGA timing counters, the framebuffer RAM and the host pixel-load interface.

Parameters:
- H_ACTIVE, 200, visible pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- V_SHIFT, 2, log2 of vertical line replication (600 lines / 4 = 150 rows).
- FB_SIZE, 30000, framebuffer words.
- ADDR_W, 15, framebuffer address width.
- FIFO_DEPTH, 4, host write queue entries (power of two).

Ports:
- CLK  in  1  pixel clock (10 MHz domain).
- RESET_N  in  1  asynchronous, active-low reset.
- h_count  in  9  horizontal counter from timing generator.
- v_count  in  10  vertical counter from timing generator.
- wr_valid  in  1  host pixel write request.
- wr_ready  out  1  queue can accept a write.
- wr_data  in  3  pixel value {blue,green,red}.
- addr_load  in  1  load host write pointer.
- addr_in  in  ADDR_W  value for addr_load.
- clr_start  in  1  start full-screen clear (pulse).
- clr_color  in  3  colour used by the clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_addr  out  ADDR_W  framebuffer address.
- mem_we  out  1  framebuffer write enable.
- mem_wdata  out  3  framebuffer write data.
- mem_rdata  in  3  framebuffer read data (synchronous RAM, 1-cycle read).
- pix_rgb  out  3  pixel to DAC pins, 0 in blanking.

Behaviour:
- Decided: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset: mem_we=0, mem_addr=0, mem_wdata=0, pix_rgb=0, clr_busy=0, clr_done=0, wr_ready=0 while RESET_N low. FIFO empty, host pointer=0, state=IDLE. wr_ready rises the first cycle after release.
- A reset asserted mid-clear or mid-drain aborts immediately. Queued writes are discarded and no clr_done is produced.
- active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Scan-out:
  - While active: mem_addr = h_count + (v_count >> V_SHIFT) * H_ACTIVE, mem_we=0. Arithmetic is done at ADDR_W bits with no truncation of in-range values.
  - Pipeline: address is combinational from the counters in cycle N, mem_rdata is valid in N+1, pix_rgb is registered and valid in N+2.
  - A 2-stage pipelined active flag forces pix_rgb=0 for blanking positions.
- Host queue:
  - A push occurs when wr_valid && wr_ready. The entry is {host_ptr, wr_data}, and host_ptr advances by 1, wrapping FB_SIZE-1 -> 0.
  - addr_load sets host_ptr = addr_in; values >= FB_SIZE load 0.
  - addr_load and a push in the same cycle: the push uses the loaded address, and host_ptr becomes loaded+1 (with wrap).
  - wr_ready = !full && state==IDLE, from registered state. A push is never accepted while full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- States:
  - IDLE:
    - When not active and the FIFO is non-empty, pop one entry per cycle: mem_we=1, mem_addr=entry addr, mem_wdata=entry data.
    - When active, nothing is popped; entries wait.
    - A clr_start seen when the FIFO is empty moves to CLEAR with clr_ptr=0 and clr_busy=1 from the next cycle.
    - A clr_start seen when the FIFO is non-empty, or while in CLEAR, is ignored (not queued).
  - CLEAR:
    - On each non-active cycle, write clr_color at clr_ptr and increment clr_ptr.
    - clr_color is sampled on every write; changing it mid-clear is allowed.
    - Active cycles pause the clear.
    - After writing address FB_SIZE-1: go to IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
    - Host pushes are blocked (wr_ready=0) while in CLEAR.
- mem_we is never 1 while active. mem_addr is held at its last value with mem_we=0 when idle in blanking.

Test Plan:
- Reset release with counters at h=0, v=0 and a RAM preloaded with address-as-data -> pix_rgb at cycle 2 equals RAM[0] & 7. mem_we stays 0 for all of the active region.
- addr_load addr_in=399 then 3 pushes 3'b001/010/100 at h=50, v=0 -> wr_ready stays 1, no mem_we until h=200. Then RAM[399..401] = 1,2,4 on 3 consecutive cycles. Line 4 (row 1) displays them at h=199, 200 blanking excluded, next-row h=0..1.
- 5 pushes during active with wr_valid held -> wr_ready=0 after the 4th, and the 5th is accepted only after the first blanking pop.
- addr_load 29999 and 2 pushes -> writes land at 29999 then 0 (wrap). addr_in=30000 -> first write at 0.
- clr_start with clr_color=3'b101 at v=600 -> clr_busy=1, 30000 writes across blanking cycles, exactly one clr_done pulse. Next frame displays 5 everywhere. A second clr_start during the clear is ignored.
- Reset pulse mid-clear at clr_ptr=1000 -> outputs 0 asynchronously, clr_busy=0, no clr_done, FIFO empty after release.
